bcp_engine: RTL and testbench

//  Boolean-constraint-propagation responder for the DPLL solver. Scans the inclusive clause range
//  [start_clause, end_clause] handed over by control, and reads each clause from the clause table.

---
 rtl/bcp_engine.sv | 207 ++++++++++++++++++++
 tb/tb_bcp_engine.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcp_engine.sv
// Boolean-constraint-propagation engine: scans a clause range, pushes unit implications, flags the first conflict.
// Optional statistics counters are compiled in when BCP_STATS_EN is defined.
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 4
`endif
`ifndef MAX_CLAUSES_BITS
`define MAX_CLAUSES_BITS 4
`endif

module bcp_engine #(
  parameter int LITS_PER_CLAUSE = 3,
  parameter int NUM_VARS        = (1 << `MAX_VARS_BITS)
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic                                          start_bcp,
  input  logic                                          reset_bcp,
  input  logic [`MAX_CLAUSES_BITS-1:0]                  start_clause,
  input  logic [`MAX_CLAUSES_BITS-1:0]                  end_clause,
  output logic                                          bcp_busy,
  output logic                                          conflict,
  output logic [`MAX_CLAUSES_BITS-1:0]                  bcp_clause_idx,
  output logic                                          clause_rd_en,
  output logic [`MAX_CLAUSES_BITS-1:0]                  clause_rd_idx,
  input  logic [LITS_PER_CLAUSE*(`MAX_VARS_BITS+1)-1:0] clause_lits,
  input  logic [NUM_VARS-1:0]                           assigned_vec,
  input  logic [NUM_VARS-1:0]                           value_vec,
  input  logic                                          full_imply,
  output logic                                          push_imply,
  output logic [`MAX_VARS_BITS-1:0]                     var_in_imply,
  output logic                                          val_in_imply,
  output logic                                          type_in_imply,
  output logic [1:0]                                    bcp_state
`ifdef BCP_STATS_EN
  ,
  output logic [31:0]                                   stat_clauses,
  output logic [31:0]                                   stat_implies
`endif
);

  localparam int VB  = `MAX_VARS_BITS;
  localparam int CB  = `MAX_CLAUSES_BITS;
  localparam int LW  = VB + 1;
  localparam int LCW = $clog2(LITS_PER_CLAUSE + 1);

  // Handshake: push_imply is a one-cycle strobe; the imply stack accepts it on
  // the rising edge where push_imply=1. The engine never asserts it while
  // full_imply=1, so a stalled unit waits in PUSH holding var/val.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EVAL  = 2'd2,
    PUSH  = 2'd3
  } state_t;

  state_t state, state_n;

  logic [CB-1:0]  idx;
  logic [CB-1:0]  end_idx;
  logic           conflict_r;
  logic [VB-1:0]  held_var;
  logic           held_val;

  logic           advance;
  logic           set_conflict;
  logic           hold_push;
  logic           abort;

  logic           any_true;
  logic [LCW-1:0] n_unassigned;
  logic [VB-1:0]  unit_var;
  logic           unit_neg;
  logic [LW-1:0]  lit;
  logic [VB-1:0]  lit_var;
  logic           lit_neg;

  assign abort = reset | reset_bcp;

  // Clause classification; slot 0 sits in the least-significant literal field.
  always_comb begin
    any_true     = 1'b0;
    n_unassigned = '0;
    unit_var     = '0;
    unit_neg     = 1'b0;
    lit          = '0;
    lit_var      = '0;
    lit_neg      = 1'b0;
    for (int i = 0; i < LITS_PER_CLAUSE; i++) begin
      lit     = clause_lits[i*LW +: LW];
      lit_var = lit[VB-1:0];
      lit_neg = lit[VB];
      if (lit_var != '0) begin
        if (assigned_vec[lit_var]) begin
          if (value_vec[lit_var] != lit_neg) any_true = 1'b1;
        end else begin
          n_unassigned = n_unassigned + LCW'(1);
          unit_var     = lit_var;
          unit_neg     = lit_neg;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (abort) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n      = state;
    advance      = 1'b0;
    set_conflict = 1'b0;
    hold_push    = 1'b0;
    push_imply   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_bcp) state_n = FETCH;
      end
      FETCH: begin
        state_n = EVAL;
      end
      EVAL: begin
        if (any_true) begin
          advance = 1'b1;
        end else if (n_unassigned == '0) begin
          set_conflict = 1'b1;
          state_n      = IDLE;
        end else if (n_unassigned == LCW'(1)) begin
          if (!full_imply) begin
            push_imply = 1'b1;
            advance    = 1'b1;
          end else begin
            hold_push = 1'b1;
            state_n   = PUSH;
          end
        end else begin
          advance = 1'b1;
        end
      end
      PUSH: begin
        if (!full_imply) begin
          push_imply = 1'b1;
          advance    = 1'b1;
        end
      end
    endcase
    if (advance) state_n = (idx == end_idx) ? IDLE : FETCH;
    // An abort suppresses every side effect of the current cycle.
    if (abort) begin
      state_n      = IDLE;
      advance      = 1'b0;
      set_conflict = 1'b0;
      hold_push    = 1'b0;
      push_imply   = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (abort) begin
      idx        <= '0;
      end_idx    <= '0;
      conflict_r <= 1'b0;
      held_var   <= '0;
      held_val   <= 1'b0;
    end else begin
      if (state == IDLE && start_bcp) begin
        idx        <= start_clause;
        // A reversed range collapses to a single-clause scan of start_clause.
        end_idx    <= (end_clause < start_clause) ? start_clause : end_clause;
        conflict_r <= 1'b0;
      end
      if (advance && idx != end_idx) idx <= idx + CB'(1);
      if (set_conflict) conflict_r <= 1'b1;
      if (hold_push) begin
        held_var <= unit_var;
        held_val <= ~unit_neg;
      end
    end
  end

  assign bcp_busy       = (state != IDLE);
  assign conflict       = conflict_r;
  assign bcp_clause_idx = idx;
  assign clause_rd_en   = (state == FETCH);
  assign clause_rd_idx  = idx;
  assign var_in_imply   = (state == PUSH) ? held_var : unit_var;
  assign val_in_imply   = (state == PUSH) ? held_val : ~unit_neg;
  assign type_in_imply  = 1'b1;
  assign bcp_state      = state;

`ifdef BCP_STATS_EN
  // Saturating counters survive reset_bcp so control can read totals across aborts.
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_clauses <= '0;
      stat_implies <= '0;
    end else begin
      if (state == EVAL && !reset_bcp && stat_clauses != 32'hFFFF_FFFF)
        stat_clauses <= stat_clauses + 32'd1;
      if (push_imply && stat_implies != 32'hFFFF_FFFF)
        stat_implies <= stat_implies + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bcp_engine.sv
// Self-checking bench for bcp_engine: directed scenarios plus randomized scans against a clause-level model.
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 4
`endif
`ifndef MAX_CLAUSES_BITS
`define MAX_CLAUSES_BITS 4
`endif

module tb_bcp_engine;

  localparam int VB   = `MAX_VARS_BITS;
  localparam int CB   = `MAX_CLAUSES_BITS;
  localparam int LW   = VB + 1;
  localparam int NL   = 3;
  localparam int NV   = (1 << VB);
  localparam int NC   = (1 << CB);

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start_bcp = 1'b0;
  logic              reset_bcp = 1'b0;
  logic [CB-1:0]     start_clause = '0;
  logic [CB-1:0]     end_clause = '0;
  logic              bcp_busy;
  logic              conflict;
  logic [CB-1:0]     bcp_clause_idx;
  logic              clause_rd_en;
  logic [CB-1:0]     clause_rd_idx;
  logic [NL*LW-1:0]  clause_lits = '0;
  logic [NV-1:0]     assigned_vec = '0;
  logic [NV-1:0]     value_vec = '0;
  logic              full_imply = 1'b0;
  logic              push_imply;
  logic [VB-1:0]     var_in_imply;
  logic              val_in_imply;
  logic              type_in_imply;
  logic [1:0]        bcp_state;
`ifdef BCP_STATS_EN
  logic [31:0]       stat_clauses;
  logic [31:0]       stat_implies;
`endif

  bcp_engine dut (
    .clock(clock), .reset(reset), .start_bcp(start_bcp), .reset_bcp(reset_bcp),
    .start_clause(start_clause), .end_clause(end_clause),
    .bcp_busy(bcp_busy), .conflict(conflict), .bcp_clause_idx(bcp_clause_idx),
    .clause_rd_en(clause_rd_en), .clause_rd_idx(clause_rd_idx), .clause_lits(clause_lits),
    .assigned_vec(assigned_vec), .value_vec(value_vec), .full_imply(full_imply),
    .push_imply(push_imply), .var_in_imply(var_in_imply), .val_in_imply(val_in_imply),
    .type_in_imply(type_in_imply), .bcp_state(bcp_state)
`ifdef BCP_STATS_EN
    , .stat_clauses(stat_clauses), .stat_implies(stat_implies)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- peers: clause table and imply-stack fullness ----------------
  logic [NL*LW-1:0] mem [NC];
  int full_mode  = 0;       // 0: follow full_force, 1: random stalls
  logic full_force = 1'b0;

  always @(posedge clock) begin
    if (clause_rd_en) clause_lits <= mem[clause_rd_idx];
  end

  always @(posedge clock) begin
    #1;
    full_imply = (full_mode == 1) ? ($urandom_range(0, 2) == 0) : full_force;
  end

  // ---------------- monitor ----------------
  logic [VB:0]   obs_q [$];
  logic [CB-1:0] obs_rd_q [$];
  int busy_cnt = 0;

  always @(negedge clock) begin
    if (push_imply) begin
      check("type_in_imply", 32'(type_in_imply), 32'd1);
      obs_q.push_back({var_in_imply, val_in_imply});
    end
    if (clause_rd_en) obs_rd_q.push_back(clause_rd_idx);
    if (bcp_busy) busy_cnt++;
  end

  // ---------------- reference model (clause level) ----------------
  logic [VB:0]   exp_q [$];
  logic [CB-1:0] exp_rd_q [$];
  logic          exp_conflict;
  logic [CB-1:0] exp_cidx;

  function automatic logic [LW-1:0] lit(input logic neg, input int v);
    logic [31:0] vv;
    vv = v;
    return {neg, vv[VB-1:0]};
  endfunction

  task automatic model_scan(input int s, input int e);
    int i;
    int last;
    exp_q.delete();
    exp_rd_q.delete();
    exp_conflict = 1'b0;
    exp_cidx     = '0;
    last = (e < s) ? s : e;
    i = s;
    forever begin
      int n_true, n_un, u_var;
      logic u_neg;
      logic [NL*LW-1:0] w;
      exp_rd_q.push_back(i[CB-1:0]);
      w = mem[i];
      n_true = 0; n_un = 0; u_var = 0; u_neg = 1'b0;
      for (int k = 0; k < NL; k++) begin
        logic [LW-1:0] l;
        int v;
        l = w[k*LW +: LW];
        v = int'(l[VB-1:0]);
        if (v != 0) begin
          if (!assigned_vec[v]) begin
            n_un++; u_var = v; u_neg = l[VB];
          end else if (value_vec[v] != l[VB]) begin
            n_true++;
          end
        end
      end
      if (n_true == 0 && n_un == 0) begin
        exp_conflict = 1'b1;
        exp_cidx     = i[CB-1:0];
        break;
      end
      if (n_true == 0 && n_un == 1) exp_q.push_back({u_var[VB-1:0], ~u_neg});
      if (i == last) break;
      i++;
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_reset();
    @(posedge clock); #2;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
  endtask

  task automatic run_scan(input int s, input int e);
    int budget;
    obs_q.delete();
    obs_rd_q.delete();
    @(posedge clock); #2;
    busy_cnt     = 0;
    start_clause = s[CB-1:0];
    end_clause   = e[CB-1:0];
    start_bcp    = 1'b1;
    @(posedge clock); #2;
    start_bcp = 1'b0;
    budget = 0;
    forever begin
      @(negedge clock); #1;
      if (!bcp_busy) break;
      budget++;
      if (budget > 400) begin
        check("scan_timeout", 32'(budget), 32'd0);
        break;
      end
    end
  endtask

  task automatic compare_scan(input string name, input bit check_latency);
    check({name, "_npush"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check({name, "_push"}, 32'(obs_q[i]), 32'(exp_q[i]));
    check({name, "_nread"}, 32'(obs_rd_q.size()), 32'(exp_rd_q.size()));
    for (int i = 0; i < exp_rd_q.size() && i < obs_rd_q.size(); i++)
      check({name, "_read"}, 32'(obs_rd_q[i]), 32'(exp_rd_q[i]));
    check({name, "_conflict"}, 32'(conflict), 32'(exp_conflict));
    if (exp_conflict) check({name, "_cidx"}, 32'(bcp_clause_idx), 32'(exp_cidx));
    if (check_latency) check({name, "_busy"}, 32'(busy_cnt), 32'(2 * exp_rd_q.size()));
  endtask

  task automatic set_var(input int v, input int state); // 0=F,1=T,2=unassigned
    assigned_vec[v] = (state != 2);
    value_vec[v]    = (state == 1);
  endtask

  task automatic clear_vars();
    assigned_vec = '0;
    value_vec    = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < NC; i++) mem[i] = '0;
    do_reset();
    @(negedge clock);
    check("rst_busy", 32'(bcp_busy), 32'd0);
    check("rst_conflict", 32'(conflict), 32'd0);
    check("rst_cidx", 32'(bcp_clause_idx), 32'd0);
    check("rst_rd_en", 32'(clause_rd_en), 32'd0);
    check("rst_push", 32'(push_imply), 32'd0);

    // 1: satisfied clause, no push, two busy cycles
    clear_vars(); set_var(1, 1); set_var(2, 0);
    mem[0] = {lit(0, 2), lit(1, 3), lit(0, 1)};
    model_scan(0, 0); run_scan(0, 0); compare_scan("t1", 1);

    // 2: unit clause pushes x3=0
    clear_vars(); set_var(1, 0); set_var(2, 0);
    mem[0] = {lit(1, 3), lit(0, 2), lit(0, 1)};
    model_scan(0, 0); run_scan(0, 0); compare_scan("t2", 1);
    check("t2_exp_is_x3_0", 32'(exp_q.size() == 1 ? exp_q[0] : '1), 32'({4'd3, 1'b0}));

    // 3: conflict at clause 5 stops the scan
    mem[4] = {lit(0, 0), lit(1, 2), lit(0, 0)};
    mem[5] = {lit(0, 0), lit(0, 2), lit(0, 1)};
    mem[6] = {lit(0, 0), lit(0, 0), lit(0, 3)};
    model_scan(4, 6); run_scan(4, 6); compare_scan("t3", 1);
    check("t3_cidx5", 32'(bcp_clause_idx), 32'd5);

    // 4: unit clause stalled by full_imply for three cycles
    mem[0] = {lit(1, 3), lit(0, 2), lit(0, 1)};
    full_force = 1'b1;
    @(posedge clock);
    model_scan(0, 0);
    fork
      run_scan(0, 0);
      begin
        @(posedge clock);
        repeat (4) @(posedge clock);
        #2 full_force = 1'b0;
      end
    join
    compare_scan("t4", 0);
    check("t4_busy", 32'(busy_cnt), 32'd5);

    // 5: reset_bcp during EVAL of a unit clause
    obs_q.delete();
    @(posedge clock); #2;
    start_clause = '0; end_clause = '0; start_bcp = 1'b1;
    @(posedge clock); #2;
    start_bcp = 1'b0;
    @(posedge clock); #2;
    reset_bcp = 1'b1;
    @(negedge clock);
    check("t5_push_in_abort", 32'(push_imply), 32'd0);
    @(posedge clock); #2;
    reset_bcp = 1'b0;
    @(negedge clock);
    check("t5_busy", 32'(bcp_busy), 32'd0);
    check("t5_conflict", 32'(conflict), 32'd0);
    check("t5_npush", 32'(obs_q.size()), 32'd0);

    // reversed range is a single-clause scan; range ending at the last clause
    mem[9]      = {lit(0, 0), lit(0, 0), lit(1, 3)};
    mem[NC-1]   = {lit(0, 0), lit(0, 0), lit(0, 3)};
    mem[NC-2]   = {lit(0, 4), lit(0, 0), lit(0, 5)};
    model_scan(9, 2); run_scan(9, 2); compare_scan("rev", 1);
    model_scan(NC - 2, NC - 1); run_scan(NC - 2, NC - 1); compare_scan("top", 1);

    // randomized scans, some with imply-stack stalls
    for (int t = 0; t < 40; t++) begin
      int s, e;
      for (int v = 1; v < NV; v++) set_var(v, ($urandom_range(0, 3) == 0) ? 2 : $urandom_range(0, 1));
      for (int c = 0; c < NC; c++)
        for (int k = 0; k < NL; k++)
          mem[c][k*LW +: LW] = lit($urandom_range(0, 1),
                                   ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, NV - 1));
      s = $urandom_range(0, NC - 1);
      e = ($urandom_range(0, 7) == 0) ? $urandom_range(0, NC - 1) : s + $urandom_range(0, 6);
      if (e > NC - 1) e = NC - 1;
      full_mode = (t % 3 == 0) ? 1 : 0;
      model_scan(s, e); run_scan(s, e);
      compare_scan("rnd", full_mode == 0);
      full_mode = 0;
    end

`ifdef BCP_STATS_EN
    // 6: counters after a fresh reset, clauses 1 and 3 unit
    clear_vars(); set_var(1, 1); set_var(2, 0);
    mem[0] = {lit(0, 0), lit(0, 0), lit(0, 1)};
    mem[1] = {lit(0, 0), lit(0, 2), lit(0, 3)};
    mem[2] = {lit(0, 0), lit(1, 2), lit(0, 0)};
    mem[3] = {lit(0, 0), lit(0, 2), lit(1, 4)};
    do_reset();
    model_scan(0, 3); run_scan(0, 3); compare_scan("t6", 1);
    check("t6_stat_clauses", stat_clauses, 32'd4);
    check("t6_stat_implies", stat_implies, 32'd2);
`endif

    repeat (3) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
